// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle FETCH/DECODE/EXEC/MEM/WB control FSM
// Define MULDIV_EN to add the MDWAIT state and the mul/div start/ready handshake.
module multicycle_controller #(
  parameter int OP_W     = 5,
  parameter int ALUOP_W  = 5,
  parameter int WAIT_W   = 6,
  parameter int MAX_WAIT = 40
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic [OP_W-1:0]    opCode,
  input  logic [ALUOP_W-1:0] aluOp,
  input  logic               isNotEqual,
  input  logic               isLessThan,
  input  logic               muldiv_ready,
  input  logic               muldiv_exc,
  output logic               PCwe,
  output logic               IRwe,
  output logic               Rwe,
  output logic               DMwe,
  output logic               Rwd,
  output logic               ReadRd,
  output logic               ALUinB,
  output logic [1:0]         PCsrc,
  output logic               link,
  output logic               muldiv_start,
  output logic               exc,
  output logic               illegal,
  output logic               timeout,
  output logic [2:0]         state
);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(1);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_JR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_MUL = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_DIV = ALUOP_W'(7);

`ifdef MULDIV_EN
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, MDWAIT = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4
  } state_t;
`endif

  // Jumps and illegal opcodes finish in DECODE, so they share C_NONE.
  typedef enum logic [2:0] {
    C_NONE, C_R, C_ADDI, C_LW, C_SW, C_BNE, C_BLT
  } cls_t;

  state_t st;
  cls_t   cls;
  cls_t   dec_cls;
  logic   md_op;

  function automatic cls_t classify(input logic [OP_W-1:0] op);
    cls_t c;
    case (op)
      OP_R:    c = C_R;
      OP_ADDI: c = C_ADDI;
      OP_LW:   c = C_LW;
      OP_SW:   c = C_SW;
      OP_BNE:  c = C_BNE;
      OP_BLT:  c = C_BLT;
      default: c = C_NONE;
    endcase
    return c;
  endfunction

  assign dec_cls = classify(opCode);
  assign md_op   = (aluOp == ALU_MUL) || (aluOp == ALU_DIV);

`ifdef MULDIV_EN
  logic [WAIT_W-1:0] cnt;
  logic              exc_q;
  logic              limit;
  assign limit = (cnt == WAIT_W'(MAX_WAIT));
`else
  logic [WAIT_W-1:0] unused_lim;
  logic              unused_md;
  assign unused_lim = WAIT_W'(MAX_WAIT);
  assign unused_md  = ^{muldiv_ready, muldiv_exc, unused_lim};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st  <= FETCH;
      cls <= C_NONE;
`ifdef MULDIV_EN
      cnt   <= '0;
      exc_q <= 1'b0;
`endif
    end else begin
      case (st)
        FETCH: begin
`ifdef MULDIV_EN
          exc_q <= 1'b0;
`endif
          if (run) st <= DECODE;
        end
        DECODE: begin
          cls <= dec_cls;
          if (dec_cls == C_NONE) st <= FETCH;
          else                   st <= EXEC;
        end
        EXEC: begin
          case (cls)
            C_LW, C_SW: st <= MEM;
            C_ADDI:     st <= WB;
            C_R: begin
              if (!md_op) begin
                st <= WB;
              end else begin
`ifdef MULDIV_EN
                cnt <= '0;
                st  <= MDWAIT;
`else
                st  <= FETCH;
`endif
              end
            end
            default:    st <= FETCH;
          endcase
        end
        MEM: begin
          if (cls == C_LW) st <= WB;
          else             st <= FETCH;
        end
        WB: st <= FETCH;
`ifdef MULDIV_EN
        // A ready that coincides with the limit still completes the op.
        MDWAIT: begin
          if (muldiv_ready) begin
            exc_q <= muldiv_exc;
            st    <= WB;
          end else if (limit) begin
            st <= FETCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        default: st <= FETCH;
      endcase
    end
  end

  always_comb begin
    PCwe         = 1'b0;
    IRwe         = 1'b0;
    Rwe          = 1'b0;
    DMwe         = 1'b0;
    Rwd          = 1'b0;
    ReadRd       = 1'b0;
    ALUinB       = 1'b0;
    PCsrc        = 2'd0;
    link         = 1'b0;
    muldiv_start = 1'b0;
    exc          = 1'b0;
    illegal      = 1'b0;
    timeout      = 1'b0;
    state        = 3'd0;
    if (!reset) begin
      state = st;
      case (st)
        FETCH: begin
          IRwe = run;
          PCwe = run;
        end
        DECODE: begin
          case (opCode)
            OP_J:   begin PCwe = 1'b1; PCsrc = 2'd2; end
            OP_JAL: begin PCwe = 1'b1; PCsrc = 2'd2; Rwe = 1'b1; link = 1'b1; end
            OP_JR:  begin PCwe = 1'b1; PCsrc = 2'd3; ReadRd = 1'b1; end
            default: illegal = (dec_cls == C_NONE);
          endcase
        end
        EXEC: begin
          ALUinB = (cls == C_ADDI) || (cls == C_LW) || (cls == C_SW);
          ReadRd = (cls == C_SW) || (cls == C_BNE) || (cls == C_BLT);
          if (cls == C_BNE) begin
            PCwe  = isNotEqual;
            PCsrc = 2'd1;
          end
          if (cls == C_BLT) begin
            PCwe  = ~isLessThan & isNotEqual;
            PCsrc = 2'd1;
          end
          if (cls == C_R && md_op) begin
`ifdef MULDIV_EN
            muldiv_start = 1'b1;
`else
            illegal = 1'b1;
`endif
          end
        end
        MEM: DMwe = (cls == C_SW);
        WB: begin
          Rwe = 1'b1;
          Rwd = (cls == C_LW);
`ifdef MULDIV_EN
          exc = exc_q;
`endif
        end
`ifdef MULDIV_EN
        MDWAIT: timeout = ~muldiv_ready & limit;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized instruction-level checks of multicycle_controller
// Expected per-cycle output traces are built from the instruction-sequencing rules.
module tb_multicycle_controller;

  logic       clock, reset, run;
  logic [4:0] opCode, aluOp;
  logic       isNotEqual, isLessThan, muldiv_ready, muldiv_exc;
  logic       PCwe, IRwe, Rwe, DMwe, Rwd, ReadRd, ALUinB, link;
  logic [1:0] PCsrc;
  logic       muldiv_start, exc, illegal, timeout;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  localparam int MAXW = 40;
`ifdef MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic pcwe, irwe, rwe, dmwe, rwd, readrd, aluinb;
    logic [1:0] pcsrc;
    logic link, start, exc, ill, tmo;
  } ov_t;

  ov_t  exp_q[$];
  logic rdy_q[$];

  multicycle_controller dut (
    .clock(clock), .reset(reset), .run(run), .opCode(opCode), .aluOp(aluOp),
    .isNotEqual(isNotEqual), .isLessThan(isLessThan),
    .muldiv_ready(muldiv_ready), .muldiv_exc(muldiv_exc),
    .PCwe(PCwe), .IRwe(IRwe), .Rwe(Rwe), .DMwe(DMwe), .Rwd(Rwd),
    .ReadRd(ReadRd), .ALUinB(ALUinB), .PCsrc(PCsrc), .link(link),
    .muldiv_start(muldiv_start), .exc(exc), .illegal(illegal),
    .timeout(timeout), .state(state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic ov_t cur();
    ov_t v;
    v.st = state; v.pcwe = PCwe; v.irwe = IRwe; v.rwe = Rwe; v.dmwe = DMwe;
    v.rwd = Rwd; v.readrd = ReadRd; v.aluinb = ALUinB; v.pcsrc = PCsrc;
    v.link = link; v.start = muldiv_start; v.exc = exc; v.ill = illegal;
    v.tmo = timeout;
    return v;
  endfunction

  task automatic push(input ov_t v, input logic r);
    exp_q.push_back(v);
    rdy_q.push_back(r);
  endtask

  // d = MDWAIT cycle index at which ready pulses (> MAXW means never).
  task automatic build(input logic [4:0] op, input logic [4:0] alu, input logic ne,
                       input logic lt, input int d, input logic rexc);
    ov_t v;
    bit  md_op;
    exp_q.delete();
    rdy_q.delete();
    v = '0; v.irwe = 1; v.pcwe = 1;
    push(v, 1'b0);
    v = '0; v.st = 3'd1;
    case (op)
      5'd1: begin v.pcwe = 1; v.pcsrc = 2'd2; push(v, 1'b0); return; end
      5'd3: begin v.pcwe = 1; v.pcsrc = 2'd2; v.rwe = 1; v.link = 1; push(v, 1'b0); return; end
      5'd4: begin v.pcwe = 1; v.pcsrc = 2'd3; v.readrd = 1; push(v, 1'b0); return; end
      5'd0, 5'd2, 5'd5, 5'd6, 5'd7, 5'd8: push(v, 1'b0);
      default: begin v.ill = 1; push(v, 1'b0); return; end
    endcase
    md_op = (op == 5'd0) && (alu == 5'd6 || alu == 5'd7);
    v = '0; v.st = 3'd2;
    v.aluinb = (op == 5'd5 || op == 5'd8 || op == 5'd7);
    v.readrd = (op == 5'd7 || op == 5'd2 || op == 5'd6);
    if (op == 5'd2) begin v.pcwe = ne; v.pcsrc = 2'd1; end
    if (op == 5'd6) begin v.pcwe = !lt && ne; v.pcsrc = 2'd1; end
    if (md_op) begin
      if (MD) v.start = 1;
      else    v.ill = 1;
    end
    push(v, 1'($urandom_range(0, 1)));
    if (op == 5'd2 || op == 5'd6) return;
    if (md_op && !MD) return;
    if (op == 5'd8 || op == 5'd7) begin
      v = '0; v.st = 3'd3; v.dmwe = (op == 5'd7);
      push(v, 1'b0);
      if (op == 5'd7) return;
    end
    if (md_op) begin
      for (int i = 0; i <= MAXW; i++) begin
        v = '0; v.st = 3'd5;
        if (i == d) begin
          push(v, 1'b1);
          break;
        end
        if (i == MAXW) begin
          v.tmo = 1;
          push(v, 1'b0);
          return;
        end
        push(v, 1'b0);
      end
    end
    v = '0; v.st = 3'd4; v.rwe = 1;
    v.rwd = (op == 5'd8);
    v.exc = md_op && rexc;
    push(v, 1'b0);
  endtask

  task automatic run_instr(input string name, input logic [4:0] op, input logic [4:0] alu,
                           input logic ne, input logic lt, input int d, input logic rexc);
    logic [16:0] g, e;
    build(op, alu, ne, lt, d, rexc);
    opCode = op; aluOp = alu; isNotEqual = ne; isLessThan = lt; muldiv_exc = rexc;
    for (int i = 0; i < exp_q.size(); i++) begin
      muldiv_ready = rdy_q[i];
      #2;
      total++;
      g = cur();
      e = exp_q[i];
      if (g !== e) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", name, i, g, e);
      end
      @(posedge clock); #1;
    end
    muldiv_ready = 1'b0;
  endtask

  task automatic test_reset();
    ov_t z, f;
    z = '0;
    f = '0; f.irwe = 1; f.pcwe = 1;
    reset = 1; run = 1; opCode = 5'd8; aluOp = 5'd0;
    @(posedge clock); #1;
    total++;
    if (cur() !== z) begin bad++; $display("FAIL reset_hold got=%h exp=%h", cur(), z); end
    reset = 0; #2;
    total++;
    if (cur() !== f) begin bad++; $display("FAIL reset_fetch got=%h exp=%h", cur(), f); end
    @(posedge clock); #1;
    @(posedge clock); #1;
    total++;
    if (state !== 3'd2) begin bad++; $display("FAIL reach_exec got=%0d exp=2", state); end
    #2 reset = 1; #1;
    total++;
    if (cur() !== z) begin bad++; $display("FAIL reset_async got=%h exp=%h", cur(), z); end
    @(posedge clock); #1;
    total++;
    if (cur() !== z) begin bad++; $display("FAIL reset_clocked got=%h exp=%h", cur(), z); end
    reset = 0; #2;
    total++;
    if (cur() !== f) begin bad++; $display("FAIL release_fetch got=%h exp=%h", cur(), f); end
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
  endtask

  task automatic test_run_hold();
    ov_t z;
    z = '0;
    run = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      total++;
      if (cur() !== z) begin bad++; $display("FAIL run_hold cyc=%0d got=%h exp=%h", i, cur(), z); end
      @(posedge clock); #1;
    end
    run = 1;
  endtask

  task automatic test_directed();
    run_instr("lw",        5'd8,  5'd0, 0, 0, 0,  0);
    run_instr("sw",        5'd7,  5'd0, 0, 0, 0,  0);
    run_instr("bne_taken", 5'd2,  5'd0, 1, 0, 0,  0);
    run_instr("bne_not",   5'd2,  5'd0, 0, 0, 0,  0);
    run_instr("blt_lt",    5'd6,  5'd0, 1, 1, 0,  0);
    run_instr("blt_ge",    5'd6,  5'd0, 1, 0, 0,  0);
    run_instr("jal",       5'd3,  5'd0, 0, 0, 0,  0);
    run_instr("j",         5'd1,  5'd0, 0, 0, 0,  0);
    run_instr("jr",        5'd4,  5'd0, 0, 0, 0,  0);
    run_instr("addi",      5'd5,  5'd0, 0, 0, 0,  0);
    run_instr("r_add",     5'd0,  5'd0, 0, 0, 0,  1);
    run_instr("illegal",   5'd31, 5'd0, 0, 0, 0,  0);
    run_instr("mul_exc",   5'd0,  5'd6, 0, 0, 10, 1);
    run_instr("mul_tmo",   5'd0,  5'd6, 0, 0, 99, 1);
    run_instr("div_edge",  5'd0,  5'd7, 0, 0, MAXW, 0);
    run_instr("div_fast",  5'd0,  5'd7, 0, 0, 0,  0);
  endtask

  task automatic test_random();
    int ops[9] = '{0, 5, 8, 7, 2, 6, 1, 3, 4};
    logic [4:0] op, alu;
    int d;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(9, 31));
      else op = 5'(ops[$urandom_range(0, 8)]);
      alu = 5'($urandom_range(0, 31));
      if (op == 5'd0 && $urandom_range(0, 2) == 0) alu = 5'($urandom_range(6, 7));
      d = ($urandom_range(0, 7) == 0) ? 63 : $urandom_range(0, 12);
      run_instr("random", op, alu, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                d, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset = 1; run = 0; opCode = '0; aluOp = '0;
    isNotEqual = 0; isLessThan = 0; muldiv_ready = 0; muldiv_exc = 0;
    #1;
    test_reset();
    test_run_hold();
    test_directed();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle control FSM for the ECE550 processor; next generation of the single-cycle opcode decoder. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, decodes the full control set including branches and jumps, and runs a start/ready handshake with the iterative multiplier/divider, with a bounded wait. Sits between the instruction register and the datapath write enables.

## Interface
- `OP_W`, 5: opcode width.
- `ALUOP_W`, 5: ALU op field width.
- `WAIT_W`, 6: mul/div timeout counter width.
- `MAX_WAIT`, 40: cycles allowed in MDWAIT before abort; must be < 2^WAIT_W.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `run`  in  1  FETCH proceeds only when high.
- `opCode`  in  OP_W  IR[31:27], valid from DECODE onward.
- `aluOp`  in  ALUOP_W  IR[6:2].
- `isNotEqual`, `isLessThan`  in  1  ALU compare flags, valid in EXEC.
- `muldiv_ready`  in  1  mul/div result valid (one-cycle pulse).
- `muldiv_exc`  in  1  mul/div exception, qualified by `muldiv_ready`.
- `PCwe`, `IRwe`, `Rwe`, `DMwe`  out  1  write enables.
- `Rwd`  out  1  register write data select: 1 = memory.
- `ReadRd`, `ALUinB`  out  1  as in the single-cycle decode.
- `PCsrc`  out  2  0 = PC+1, 1 = PC+1+N, 2 = target T, 3 = $rd.
- `link`  out  1  writes PC+1 to $r31.
- `muldiv_start`  out  1  one-cycle start pulse.
- `exc`  out  1  write status to $r30 (with `Rwe`).
- `illegal`, `timeout`  out  1  one-cycle fault flags.
- `state`  out  3  current state code.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDWAIT=5. Moore outputs decoded from `state` plus opcode class latched on DECODE entry.
- FETCH: when `run`, `IRwe=1`, `PCwe=1`, `PCsrc=0`, go to DECODE; otherwise hold with all strobes 0.
- DECODE: latch class. j (00001): `PCwe`, `PCsrc=2` -> FETCH. jal (00011): same, plus `Rwe`, `link` -> FETCH. jr (00100): `PCwe`, `PCsrc=3`, `ReadRd` -> FETCH. R (00000), addi (00101), lw (01000), sw (00111), bne (00010), blt (00110) -> EXEC. Any other opcode: `illegal=1` -> FETCH.
- EXEC: `ALUinB` for addi/lw/sw. `ReadRd` for sw/bne/blt. bne: `PCwe=isNotEqual`, `PCsrc=1` -> FETCH. blt: `PCwe = ~isLessThan & isNotEqual` ($rd < $rs) -> FETCH. lw/sw -> MEM. R with aluOp 00110/00111: `muldiv_start=1` -> MDWAIT. Other R and addi -> WB.
- MEM: sw: `DMwe=1` -> FETCH. lw -> WB.
- MDWAIT: counter cleared on entry, increments each cycle. On `muldiv_ready` -> WB, with `muldiv_exc` latched. If the counter reaches MAX_WAIT without ready: `timeout=1` -> FETCH with no register write. If ready and limit coincide, ready wins.
- WB: `Rwe=1`; `Rwd=1` for lw. If exc is latched: `exc=1` (datapath writes $r30) -> FETCH.

## Timing
- Reset (asynchronous): state = FETCH; latched class, exc latch and counter cleared. Every output is 0 while `reset` is high, and `state=0`.
- Cycles per instruction: j/jal/jr/illegal 2; bne/blt 3; sw 4; R/addi 4; lw 5; mul/div 5+k, where k is the number of MDWAIT cycles before ready.
- `muldiv_start` is high exactly one cycle per mul/div. Ready arriving in the start cycle is ignored.
- Reset during MDWAIT aborts without a write. The multiplier is reset by the same `reset`.

## Configuration
- `MULDIV_EN` defined: MDWAIT state, counter, and handshake are present as described.
- `MULDIV_EN` undefined: no MDWAIT state and no counter. `muldiv_start`, `exc` and `timeout` are tied to 0. R-type mul/div ops raise `illegal` in EXEC and go to FETCH with no write.

## Test plan
- Reset is asserted mid-EXEC, then released with `run=1`. Required: all outputs 0 during reset, `state=0`, then `IRwe=PCwe=1` on the first cycle after release.
- lw (01000) -> states 0,1,2,3,4 follow; `ALUinB` is high in EXEC; `Rwe=Rwd=1` only in WB. sw (00111) -> `DMwe=1` only in MEM and no `Rwe`.
- bne with `isNotEqual=1` -> `PCwe=1`, `PCsrc=1` in EXEC. blt with `isLessThan=1` -> `PCwe=0`.
- jal (00011) -> `Rwe=1`, `link=1`, `PCsrc=2` in DECODE; next state 0.
- mul (aluOp 00110), ready after 10 cycles with `muldiv_exc=1` -> one `muldiv_start` pulse, then WB with `Rwe=exc=1`. Second case: ready never arrives -> `timeout=1` after 40 MDWAIT cycles and no `Rwe`.
- Opcode 11111 -> `illegal=1` in DECODE and a return to FETCH. The same mul test with `MULDIV_EN` undefined -> `illegal` in EXEC.
